// File: rtl/npc_pred.sv
// npc_pred: next-PC generator for the pre-fetch stage.
// Holds the registered fetch PC and a direct-mapped branch target buffer.
// Selects the next fetch address by redirect priority, predicts taken
// branches with zero bubbles, and trains the BTB from branch resolution.
module npc_pred #(
  parameter int          BTB_ENTRIES = 16,
  parameter int          TAG_W       = 8,
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pf_allowin,
  input  logic        eret_flush,
  input  logic [31:0] epc,
  input  logic        exception,
  input  logic        interrupt,
  input  logic        tlb_refill,
  input  logic        status_bev,
  input  logic        status_exl,
  input  logic        cause_iv,
  input  logic        refetch,
  input  logic [31:0] refetch_pc,
  input  logic        bru_valid,
  input  logic [31:0] bru_pc,
  input  logic        bru_taken,
  input  logic [31:0] bru_target,
  input  logic        bru_mispredict,
  input  logic [31:0] bru_correct_pc,
  output logic [31:0] pf_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [31:0] next_pc,
  output logic        instr_flush
);

  localparam int IDX_W = (BTB_ENTRIES > 1) ? $clog2(BTB_ENTRIES) : 1;

  // Fetch PC register
  logic [31:0] pf_pc_q;
  logic [31:0] pf_pc_d;

  // BTB storage; lookup is combinational so entries live in flops
  logic             valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
  logic [31:0]      target_q [BTB_ENTRIES];
  logic [1:0]       ctr_q    [BTB_ENTRIES];

  // Lookup side (indexed by the current fetch PC)
  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;

  // Update side (indexed by the resolved branch PC)
  logic [IDX_W-1:0]       upd_idx;
  logic [TAG_W-1:0]       upd_tag;
  logic                   upd_hit;
  logic [1:0]             upd_ctr;
  logic [BTB_ENTRIES-1:0] upd_sel;

  logic [31:0] exc_vector;
  logic        mispredict;

  // Only the index and tag fields of the branch PC address the BTB
  logic unused_bru_pc;
  assign unused_bru_pc = ^bru_pc;

  assign look_idx = pf_pc_q[IDX_W+1:2];
  assign look_tag = pf_pc_q[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx  = bru_pc[IDX_W+1:2];
  assign upd_tag  = bru_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Per-entry write select for the branch being resolved
  for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_sel
    assign upd_sel[gi] = bru_valid && (upd_idx == IDX_W'(gi));
  end

  // BTB lookup for the current fetch PC
  always_comb begin
    look_hit    = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    pred_taken  = look_hit && ctr_q[look_idx][1];
    pred_target = target_q[look_idx];
  end

  // Hit detection and saturating counter step for the resolved branch
  always_comb begin
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_ctr = ctr_q[upd_idx];
    if (bru_taken) begin
      if (ctr_q[upd_idx] != 2'b11) upd_ctr = ctr_q[upd_idx] + 2'b01;
    end else begin
      if (ctr_q[upd_idx] != 2'b00) upd_ctr = ctr_q[upd_idx] - 2'b01;
    end
  end

  // Exception vector from the committing exception type and CP0 state
  always_comb begin
    exc_vector = 32'h8000_0180;
    if (interrupt) begin
      case ({status_bev, status_exl, cause_iv})
        3'b000:  exc_vector = 32'h8000_0180;
        3'b001:  exc_vector = 32'h8000_2000;
        3'b010,
        3'b011:  exc_vector = 32'h8000_0180;
        3'b100:  exc_vector = 32'hBFC0_0380;
        3'b101:  exc_vector = 32'hBFC0_0400;
        default: exc_vector = 32'hBFC0_0380;
      endcase
    end else if (tlb_refill) begin
      case ({status_bev, status_exl})
        2'b00:   exc_vector = 32'h8000_0000;
        2'b01:   exc_vector = 32'h8000_0180;
        2'b10:   exc_vector = 32'hBFC0_0200;
        default: exc_vector = 32'hBFC0_0380;
      endcase
    end else begin
      exc_vector = status_bev ? 32'hBFC0_0380 : 32'h8000_0180;
    end
  end

  // Next-PC priority select; redirects ignore pf_allowin
  always_comb begin
    mispredict = bru_valid && bru_mispredict;
    if (eret_flush)                    pf_pc_d = epc;
    else if (exception)                pf_pc_d = exc_vector;
    else if (refetch)                  pf_pc_d = refetch_pc;
    else if (mispredict)               pf_pc_d = bru_correct_pc;
    else if (pf_allowin && pred_taken) pf_pc_d = pred_target;
    else if (pf_allowin)               pf_pc_d = pf_pc_q + 32'd4;
    else                               pf_pc_d = pf_pc_q;
  end

  assign next_pc     = pf_pc_d;
  assign pf_pc       = pf_pc_q;
  assign instr_flush = eret_flush | exception | refetch | mispredict;

  // Fetch PC register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pf_pc_q <= RESET_PC;
    else         pf_pc_q <= pf_pc_d;
  end

  // BTB training: update on hit, allocate on taken miss
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        if (upd_sel[i]) begin
          if (upd_hit) begin
            ctr_q[i] <= upd_ctr;
            if (bru_taken) target_q[i] <= bru_target;
          end else if (bru_taken) begin
            valid_q[i]  <= 1'b1;
            tag_q[i]    <= upd_tag;
            target_q[i] <= bru_target;
            ctr_q[i]    <= 2'b10;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_npc_pred.sv
// tb_npc_pred: randomized + directed bench for npc_pred.
// A driver applies one stimulus per cycle and pushes the reference model's
// expectation; a monitor pops and compares once outputs have settled.
module tb_npc_pred;

  localparam int          N        = 16;
  localparam int          TW       = 8;
  localparam int          IW       = 4;
  localparam logic [31:0] RST_PC   = 32'hBFC0_0000;
  localparam int          NRAND    = 2000;

  typedef struct {
    bit        allow;
    bit        eret;
    bit [31:0] epc;
    bit        exc;
    bit        intr;
    bit        tlbr;
    bit        bev;
    bit        exl;
    bit        iv;
    bit        rf;
    bit [31:0] rf_pc;
    bit        bv;
    bit [31:0] bpc;
    bit        btaken;
    bit [31:0] btgt;
    bit        bmis;
    bit [31:0] bcorr;
  } stim_t;

  typedef struct {
    bit [31:0] pf_pc;
    bit [31:0] next_pc;
    bit        ptaken;
    bit [31:0] ptarget;
    bit        flush;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pf_allowin = 1'b0, eret_flush = 1'b0, exception = 1'b0;
  logic        interrupt = 1'b0, tlb_refill = 1'b0, status_bev = 1'b0;
  logic        status_exl = 1'b0, cause_iv = 1'b0, refetch = 1'b0;
  logic        bru_valid = 1'b0, bru_taken = 1'b0, bru_mispredict = 1'b0;
  logic [31:0] epc = '0, refetch_pc = '0, bru_pc = '0, bru_target = '0;
  logic [31:0] bru_correct_pc = '0;
  logic [31:0] pf_pc, pred_target, next_pc;
  logic        pred_taken, instr_flush;

  npc_pred #(.BTB_ENTRIES(N), .TAG_W(TW), .RESET_PC(RST_PC)) dut (
    .clk(clk), .resetn(resetn), .pf_allowin(pf_allowin),
    .eret_flush(eret_flush), .epc(epc), .exception(exception),
    .interrupt(interrupt), .tlb_refill(tlb_refill),
    .status_bev(status_bev), .status_exl(status_exl), .cause_iv(cause_iv),
    .refetch(refetch), .refetch_pc(refetch_pc), .bru_valid(bru_valid),
    .bru_pc(bru_pc), .bru_taken(bru_taken), .bru_target(bru_target),
    .bru_mispredict(bru_mispredict), .bru_correct_pc(bru_correct_pc),
    .pf_pc(pf_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .next_pc(next_pc), .instr_flush(instr_flush)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [31:0] m_pc;
  bit        m_valid  [N];
  bit [31:0] m_tag    [N];
  bit [31:0] m_target [N];
  int        m_ctr    [N];

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic int idx_of(bit [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic bit [31:0] tag_of(bit [31:0] pc);
    return (pc / (4 * N)) % (1 << TW);
  endfunction

  function automatic bit [31:0] vec_of(stim_t s);
    if (s.intr) begin
      if (!s.bev) return (!s.exl && s.iv) ? 32'h8000_2000 : 32'h8000_0180;
      return (!s.exl && s.iv) ? 32'hBFC0_0400 : 32'hBFC0_0380;
    end
    if (s.tlbr) begin
      if (!s.bev) return s.exl ? 32'h8000_0180 : 32'h8000_0000;
      return s.exl ? 32'hBFC0_0380 : 32'hBFC0_0200;
    end
    return s.bev ? 32'hBFC0_0380 : 32'h8000_0180;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
  endtask

  function automatic exp_t model_eval(stim_t s);
    exp_t e;
    int   i = idx_of(m_pc);
    bit   hit = m_valid[i] && (m_tag[i] == tag_of(m_pc));
    e.pf_pc   = m_pc;
    e.ptaken  = hit && (m_ctr[i] >= 2);
    e.ptarget = m_target[i];
    e.flush   = s.eret || s.exc || s.rf || (s.bv && s.bmis);
    if (s.eret)                   e.next_pc = s.epc;
    else if (s.exc)               e.next_pc = vec_of(s);
    else if (s.rf)                e.next_pc = s.rf_pc;
    else if (s.bv && s.bmis)      e.next_pc = s.bcorr;
    else if (s.allow && e.ptaken) e.next_pc = e.ptarget;
    else if (s.allow)             e.next_pc = m_pc + 32'd4;
    else                          e.next_pc = m_pc;
    return e;
  endfunction

  task automatic model_commit(stim_t s, exp_t e);
    int i;
    m_pc = e.next_pc;
    if (s.bv) begin
      i = idx_of(s.bpc);
      if (m_valid[i] && m_tag[i] == tag_of(s.bpc)) begin
        if (s.btaken) begin
          if (m_ctr[i] < 3) m_ctr[i]++;
          m_target[i] = s.btgt;
        end else if (m_ctr[i] > 0) begin
          m_ctr[i]--;
        end
      end else if (s.btaken) begin
        m_valid[i] = 1; m_tag[i] = tag_of(s.bpc);
        m_target[i] = s.btgt; m_ctr[i] = 2;
      end
    end
  endtask

  // ---------------- driver ----------------
  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic drive(stim_t s);
    pf_allowin = s.allow; eret_flush = s.eret; epc = s.epc;
    exception = s.exc; interrupt = s.intr; tlb_refill = s.tlbr;
    status_bev = s.bev; status_exl = s.exl; cause_iv = s.iv;
    refetch = s.rf; refetch_pc = s.rf_pc; bru_valid = s.bv;
    bru_pc = s.bpc; bru_taken = s.btaken; bru_target = s.btgt;
    bru_mispredict = s.bmis; bru_correct_pc = s.bcorr;
  endtask

  task automatic step(stim_t s);
    exp_t e;
    @(negedge clk);
    drive(s);
    e = model_eval(s);
    exp_q.push_back(e);
    @(posedge clk);
    model_commit(s, e);
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    drive(idle());
    resetn = 1'b0;
    model_reset();
    e = model_eval(idle());
    exp_q.push_back(e);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic redirect(bit [31:0] pc);
    stim_t s = idle();
    s.rf = 1; s.rf_pc = pc;
    step(s);
  endtask

  task automatic train(bit [31:0] pc, bit taken, bit [31:0] tgt);
    stim_t s = idle();
    s.bv = 1; s.bpc = pc; s.btaken = taken; s.btgt = tgt;
    step(s);
  endtask

  function automatic bit [31:0] pool_pc();
    return RST_PC + 32'(4 * $urandom_range(0, 63));
  endfunction

  function automatic bit rnd(int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (pf_pc !== e.pf_pc) begin
        miscompares++;
        $display("FAIL pf_pc: got %08h expected %08h", pf_pc, e.pf_pc);
      end
      if (next_pc !== e.next_pc) begin
        miscompares++;
        $display("FAIL next_pc: got %08h expected %08h (pf_pc %08h)", next_pc, e.next_pc, e.pf_pc);
      end
      if (pred_taken !== e.ptaken) begin
        miscompares++;
        $display("FAIL pred_taken: got %0b expected %0b (pf_pc %08h)", pred_taken, e.ptaken, e.pf_pc);
      end
      if (e.ptaken && pred_target !== e.ptarget) begin
        miscompares++;
        $display("FAIL pred_target: got %08h expected %08h", pred_target, e.ptarget);
      end
      if (instr_flush !== e.flush) begin
        miscompares++;
        $display("FAIL instr_flush: got %0b expected %0b", instr_flush, e.flush);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    model_reset();
    do_reset();

    // Sequential fetch, then hold
    s = idle(); s.allow = 1;
    repeat (3) step(s);
    s.allow = 0;
    repeat (2) step(s);

    // Interrupt with IV, then TLB refill, both with pf_allowin low
    s = idle(); s.exc = 1; s.intr = 1; s.iv = 1;
    step(s);
    step(idle());
    s = idle(); s.exc = 1; s.tlbr = 1;
    step(s);
    step(idle());

    // All redirect sources at once: eret wins
    s = idle(); s.eret = 1; s.epc = 32'h8000_1234; s.exc = 1; s.rf = 1;
    s.rf_pc = 32'h1111_1110; s.bv = 1; s.bmis = 1; s.bcorr = 32'h2222_2220;
    step(s);
    step(idle());

    // Taken branch allocates, then predicted on fetch
    train(32'hBFC0_0010, 1, 32'hBFC0_0100);
    redirect(32'hBFC0_0010);
    s = idle(); s.allow = 1;
    step(s);
    step(idle());

    // Not-taken twice drops prediction; taken twice restores it
    train(32'hBFC0_0010, 0, 32'h0);
    train(32'hBFC0_0010, 0, 32'h0);
    redirect(32'hBFC0_0010);
    step(idle());
    train(32'hBFC0_0010, 1, 32'hBFC0_0100);
    redirect(32'hBFC0_0010);
    step(idle());
    train(32'hBFC0_0010, 1, 32'hBFC0_0100);
    redirect(32'hBFC0_0010);
    step(idle());

    // Aliasing PC (same index, different tag) replaces the entry
    train(32'hBFC0_0010 + 32'(4 * N), 1, 32'hBFC0_0200);
    redirect(32'hBFC0_0010);
    step(idle());
    redirect(32'hBFC0_0010 + 32'(4 * N));
    step(idle());

    // Randomized traffic with one mid-run reset
    for (int n = 0; n < NRAND; n++) begin
      if (n == NRAND / 2) do_reset();
      s = idle();
      s.allow  = rnd(75);
      s.eret   = rnd(3);   s.epc   = pool_pc();
      s.exc    = rnd(3);   s.intr  = rnd(40); s.tlbr = rnd(40);
      s.bev    = rnd(50);  s.exl   = rnd(50); s.iv   = rnd(50);
      s.rf     = rnd(3);   s.rf_pc = pool_pc();
      s.bv     = rnd(35);  s.bpc   = pool_pc();
      s.btaken = rnd(60);  s.btgt  = pool_pc();
      s.bmis   = rnd(25);  s.bcorr = pool_pc();
      step(s);
    end

    drive(idle());
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
